ddr_rd_burst_ctrl: RTL and testbench

AXI4 read-burst initiator for the DDR test path, the read-side counterpart of the write data generator. On a start pulse it sweeps a byte-address window with fixed-length INCR read bursts and accepts the R beats. For each beat it presents the per-beat byte address, a data-enable strobe and the beat data to the read data checker, all three aligned to the same cycle. It also flags AXI protocol and response errors.

---
 rtl/ddr_test_pkg.sv | 26 ++
 rtl/ddr_rd_addr_seq.sv | 55 +++++
 rtl/ddr_rd_burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_ddr_rd_burst_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR test path: AXI encodings, the read FSM
// state type and a constant-friendly clog2.
package ddr_test_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } rd_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_rd_addr_seq.sv
// Burst base / beat counter arithmetic for the read sweep, including the
// end-of-window decision taken at the last beat of each burst.
module ddr_rd_addr_seq
    import ddr_test_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH = 256,
    parameter int          BURST_LEN      = 16,
    parameter logic [31:0] ADDR_START     = 32'h0000_0000,
    parameter logic [31:0] ADDR_END       = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic        clear_beat,
    input  logic        beat_step,
    output logic [31:0] base,
    output logic [31:0] beat_addr,
    output logic        last_beat,
    output logic        window_end
);

    localparam int          BEAT_BYTES  = AXI_DATA_WIDTH / 8;
    localparam int          BEAT_SHIFT  = clog2(BEAT_BYTES);
    localparam logic [32:0] BURST_BYTES = 33'(BURST_LEN * BEAT_BYTES);
    localparam logic [7:0]  LAST_CNT    = 8'(BURST_LEN - 1);

    logic [7:0]  beat_cnt;
    logic [32:0] next_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            beat_cnt <= '0;
        end else begin
            if (load) begin
                base <= ADDR_START;
            end else if (advance) begin
                base <= next_base[31:0];
            end
            if (clear_beat) begin
                beat_cnt <= '0;
            end else if (beat_step) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    // The 33rd bit catches a window that would wrap past 4 GiB.
    assign next_base  = {1'b0, base} + BURST_BYTES;
    assign window_end = next_base[32] || (next_base[31:0] > ADDR_END);
    assign last_beat  = (beat_cnt == LAST_CNT);
    assign beat_addr  = base + (32'(beat_cnt) << BEAT_SHIFT);

endmodule

// File: rtl/ddr_rd_burst_ctrl.sv
// AXI4 read-burst initiator: sweeps a byte window with fixed INCR bursts and
// forwards each accepted beat, with its byte address, to the read checker.
module ddr_rd_burst_ctrl
    import ddr_test_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH = 256,
    parameter int          AXI_ID_WIDTH   = 4,
    parameter int          BURST_LEN      = 16,
    parameter logic [31:0] ADDR_START     = 32'h0000_0000,
    parameter logic [31:0] ADDR_END       = 32'h0000_FFFF
) (
    input  logic                      SysClk,
    input  logic                      SysRst_N,
    input  logic                      RdStart,
    output logic                      RdBusy,
    output logic                      RdDone,
    output logic                      RespErr,
    output logic [AXI_ID_WIDTH-1:0]   ARID,
    output logic [31:0]               ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]   RID,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,
    output logic [31:0]               RdAddrOut,
    output logic                      RdDataEn,
    output logic [AXI_DATA_WIDTH-1:0] RdDataOut,
    output rd_state_t                 dbg_state
);

    // Handshakes: a transfer happens on a rising edge where VALID and READY are
    // both high; ARVALID/ARADDR are held until accepted, RREADY is high only in DATA.

    rd_state_t   state;
    logic [31:0] base;
    logic [31:0] beat_addr;
    logic        last_beat;
    logic        window_end;
    logic        start_acc;
    logic        ar_hs;
    logic        r_hs;
    logic        beat_err;

    assign start_acc = (state == ST_IDLE) && RdStart;
    assign ar_hs     = (state == ST_ADDR) && ARVALID && ARREADY;
    assign r_hs      = (state == ST_DATA) && RVALID && RREADY;
    assign beat_err  = (RRESP != AXI_RESP_OKAY) || (RID != '0) || (RLAST != last_beat);

    ddr_rd_addr_seq #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .BURST_LEN      (BURST_LEN),
        .ADDR_START     (ADDR_START),
        .ADDR_END       (ADDR_END)
    ) u_addr_seq (
        .clk        (SysClk),
        .rst_n      (SysRst_N),
        .load       (start_acc),
        .advance    (r_hs && last_beat && !window_end),
        .clear_beat (ar_hs),
        .beat_step  (r_hs),
        .base       (base),
        .beat_addr  (beat_addr),
        .last_beat  (last_beat),
        .window_end (window_end)
    );

    assign ARID      = '0;
    assign ARLEN     = 8'(BURST_LEN - 1);
    assign ARSIZE    = 3'(clog2(AXI_DATA_WIDTH / 8));
    assign ARBURST   = AXI_BURST_INCR;
    assign ARADDR    = base;
    assign dbg_state = state;

    always_ff @(posedge SysClk or negedge SysRst_N) begin
        if (!SysRst_N) begin
            state     <= ST_IDLE;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            RdBusy    <= 1'b0;
            RdDone    <= 1'b0;
            RespErr   <= 1'b0;
            RdDataEn  <= 1'b0;
            RdAddrOut <= '0;
            RdDataOut <= '0;
        end else begin
            RdDone   <= 1'b0;
            RdDataEn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (RdStart) begin
                        RespErr <= 1'b0;
                        RdBusy  <= 1'b1;
                        ARVALID <= 1'b1;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        RdDataEn  <= 1'b1;
                        RdDataOut <= RDATA;
                        RdAddrOut <= beat_addr;
                        if (beat_err) begin
                            RespErr <= 1'b1;
                        end
                        // The burst closes on the counted beat even if RLAST disagrees.
                        if (last_beat) begin
                            RREADY <= 1'b0;
                            if (window_end) begin
                                RdDone <= 1'b1;
                                RdBusy <= 1'b0;
                                state  <= ST_DONE;
                            end else begin
                                ARVALID <= 1'b1;
                                state   <= ST_ADDR;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// Bench for ddr_rd_burst_ctrl: randomized AXI read slave, window/beat model
// with an expected-beat queue, and an every-cycle output compare.
`timescale 1ns/1ps
module tb_ddr_rd_burst_ctrl;
    import ddr_test_pkg::*;

    localparam int          DW      = 256;
    localparam int          IW      = 4;
    localparam int          BL      = 16;
    localparam logic [31:0] A_START = 32'h0000_0000;
    localparam logic [31:0] A_END   = 32'h0000_03FF;
    localparam int          BEAT_B  = DW / 8;
    localparam int          BURST_B = BL * BEAT_B;

    logic          SysClk;
    logic          SysRst_N;
    logic          RdStart;
    logic          RdBusy;
    logic          RdDone;
    logic          RespErr;
    logic [IW-1:0] ARID;
    logic [31:0]   ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic [31:0]   RdAddrOut;
    logic          RdDataEn;
    logic [DW-1:0] RdDataOut;
    rd_state_t     dbg_state;

    ddr_rd_burst_ctrl #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .BURST_LEN      (BL),
        .ADDR_START     (A_START),
        .ADDR_END       (A_END)
    ) dut (
        .SysClk    (SysClk),
        .SysRst_N  (SysRst_N),
        .RdStart   (RdStart),
        .RdBusy    (RdBusy),
        .RdDone    (RdDone),
        .RespErr   (RespErr),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RdAddrOut (RdAddrOut),
        .RdDataEn  (RdDataEn),
        .RdDataOut (RdDataOut),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic [31:0]   addr;
        logic [DW-1:0] data;
        bit            err;
        bit            last;
    } beat_t;

    beat_t         exp_q[$];
    logic [31:0]   ar_seen[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            done_cnt = 0;
    int            beats_seen = 0;
    bit            model_err = 0;
    bit            start_pending = 0;
    logic [31:0]   last_addr = '0;
    logic [DW-1:0] last_data = '0;

    // clock / reset
    initial begin
        SysClk = 1'b0;
        forever #5 SysClk = ~SysClk;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = $urandom();
        end
        return d;
    endfunction

    function automatic int ar_delay(input int dly);
        return (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    endfunction

    // every-cycle compare against the beat queue and the sticky-error model
    initial begin
        beat_t e;
        forever begin
            @(posedge SysClk);
            #1;
            if (!SysRst_N) begin
                chk("rst_arvalid", ARVALID, 0);
                chk("rst_rready", RREADY, 0);
                chk("rst_busy", RdBusy, 0);
                chk("rst_done", RdDone, 0);
                chk("rst_resperr", RespErr, 0);
                chk("rst_dataen", RdDataEn, 0);
                chk("rst_addrout", RdAddrOut, 0);
                chk("rst_dataout", RdDataOut, 0);
                chk("rst_araddr", ARADDR, 0);
                chk("rst_const", {ARID, ARLEN, ARSIZE, ARBURST}, {4'd0, 8'd15, 3'd5, 2'b01});
                model_err     = 0;
                last_addr     = '0;
                last_data     = '0;
                start_pending = 0;
                exp_q.delete();
            end else begin
                if (start_pending) begin
                    model_err     = 0;
                    start_pending = 0;
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_en", RdDataEn, 1);
                    chk("beat_addr", RdAddrOut, e.addr);
                    chk("beat_data", RdDataOut, e.data);
                    chk("beat_done", RdDone, e.last);
                    chk("beat_busy", RdBusy, !e.last);
                    model_err  = model_err | e.err;
                    last_addr  = e.addr;
                    last_data  = e.data;
                    beats_seen++;
                end else begin
                    chk("idle_en", RdDataEn, 0);
                    chk("hold_addr", RdAddrOut, last_addr);
                    chk("hold_data", RdDataOut, last_data);
                    chk("idle_done", RdDone, 0);
                end
                chk("resp_err", RespErr, model_err);
                chk("ar_in_data", ARVALID && RREADY, 0);
                if (RdDone) done_cnt++;
            end
        end
    end

    // driver: one full sweep acting as the AXI read slave
    task automatic run_sweep(input int rmode, input int ar_dly, input int err_kind,
                             input int err_beat, input int abort_at, input bit spurious);
        logic [31:0]   ar_q[$];
        logic [63:0]   b;
        logic [DW-1:0] d;
        int            total, k, burst_beat, wait_ar, cyc, done0;
        bit            tog, want, ar_low, ar_hold;
        beat_t         e;
        b = 64'(A_START);
        forever begin
            ar_q.push_back(b[31:0]);
            if (b + 64'(BURST_B) > 64'(A_END)) break;
            b = b + 64'(BURST_B);
        end
        total = ar_q.size() * BL;
        ar_seen.delete();
        k = 0; burst_beat = 0; cyc = 0; tog = 1; ar_low = 0; ar_hold = 0;
        wait_ar = ar_delay(ar_dly);
        @(negedge SysClk);
        RdStart = 1'b1;
        start_pending = 1;
        done0 = done_cnt;
        while (k < total && cyc < 4000) begin
            @(negedge SysClk);
            cyc++;
            RdStart = spurious && ($urandom_range(0, 15) == 0);
            if (abort_at >= 0 && k == abort_at) begin
                RdStart = 1'b0; RVALID = 1'b0; ARREADY = 1'b0;
                SysRst_N = 1'b0;
                #1;
                chk("async_arvalid", ARVALID, 0);
                chk("async_rready", RREADY, 0);
                repeat (3) @(negedge SysClk);
                SysRst_N = 1'b1;
                return;
            end
            if (ar_low) chk("ar_drop", ARVALID, 0);
            if (ar_hold) chk("ar_hold_valid", ARVALID, 1);
            ar_low = 0; ar_hold = 0;
            ARREADY = 1'b0;
            if (ARVALID) begin
                chk("ar_pending", ar_q.size() > 0, 1);
                if (ar_q.size() > 0) begin
                    chk("araddr", ARADDR, ar_q[0]);
                    chk("ar_const", {ARID, ARLEN, ARSIZE, ARBURST}, {4'd0, 8'(BL - 1), 3'd5, 2'b01});
                    if (wait_ar > 0) begin
                        wait_ar--;
                        ar_hold = 1;
                    end else begin
                        ARREADY = 1'b1;
                        ar_seen.push_back(ARADDR);
                        void'(ar_q.pop_front());
                        ar_low  = 1;
                        wait_ar = ar_delay(ar_dly);
                    end
                end
            end
            RVALID = 1'b0; RLAST = 1'b0; RID = '0; RRESP = 2'b00;
            RDATA = rand_data();
            if (RREADY) begin
                want = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : tog;
                tog  = ~tog;
                if (want) begin
                    d = rand_data();
                    RVALID = 1'b1;
                    RDATA  = d;
                    RLAST  = (burst_beat == BL - 1);
                    if (k == err_beat) begin
                        case (err_kind)
                            1: RRESP = 2'b10;
                            2: RLAST = 1'b1;
                            3: RID   = 4'd1;
                            4: RLAST = 1'b0;
                            default: ;
                        endcase
                    end
                    e.addr = A_START + 32'(k * BEAT_B);
                    e.data = d;
                    e.err  = (RRESP != 2'b00) || (RID != '0) || (RLAST != (burst_beat == BL - 1));
                    e.last = (k == total - 1);
                    exp_q.push_back(e);
                    k++;
                    burst_beat = (burst_beat + 1) % BL;
                end
            end
        end
        @(negedge SysClk);
        RdStart = 1'b0; RVALID = 1'b0; RLAST = 1'b0; ARREADY = 1'b0; RRESP = 2'b00; RID = '0;
        repeat (3) @(negedge SysClk);
        chk("sweep_beats", k, total);
        chk("done_count", done_cnt - done0, 1);
        chk("ar_all_issued", ar_q.size(), 0);
        chk("idle_busy", RdBusy, 0);
    endtask

    initial begin
        SysRst_N = 1'b1;
        RdStart = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
        RID = '0; RRESP = 2'b00; RDATA = '0;
        #1 SysRst_N = 1'b0;
        repeat (3) @(negedge SysClk);
        SysRst_N = 1'b1;
        @(negedge SysClk);

        // back-to-back OKAY sweep, pinned with literal expectations
        beats_seen = 0;
        run_sweep(0, 0, 0, -1, -1, 0);
        chk("lit_beats", beats_seen, 32);
        chk("lit_last_addr", last_addr, 32'h3E0);
        chk("lit_ar_count", ar_seen.size(), 2);
        chk("lit_ar0", ar_seen[0], 32'h000);
        chk("lit_ar1", ar_seen[1], 32'h200);
        chk("lit_err_clean", RespErr, 0);

        run_sweep(0, 10, 0, -1, -1, 0);   // ARREADY held low 10 cycles
        run_sweep(2, 1, 0, -1, -1, 0);    // RVALID toggling 1,0,1,0

        run_sweep(0, 0, 1, 5, -1, 0);     // RRESP=SLVERR on beat 5
        chk("lit_err_sticky", RespErr, 1);
        run_sweep(1, 0, 0, -1, -1, 0);
        chk("lit_err_cleared", RespErr, 0);

        run_sweep(0, 0, 2, 14, -1, 0);    // early RLAST at BeatCnt 14
        chk("lit_early_last", RespErr, 1);
        run_sweep(1, -1, 3, 20, -1, 0);   // RID mismatch
        run_sweep(0, -1, 4, 31, -1, 0);   // missing RLAST on final beat

        run_sweep(0, 0, 0, -1, 20, 0);    // reset mid-DATA
        repeat (2) @(negedge SysClk);
        run_sweep(0, 0, 0, -1, -1, 0);
        chk("lit_restart_ar0", ar_seen[0], 32'h000);

        for (int i = 0; i < 4; i++) begin
            run_sweep(int'($urandom_range(0, 2)), -1, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 31)), -1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
